map_beta_recursion: RTL and testbench

- Parametrised max-log-MAP backward (beta) state-metric recursion unit for the 8-state turbo-constituent MAP decoder.
- Successor to the fixed 12-bit, 8-input beta stage. Adds the following:
  - parametrised metric, branch-metric and block-length widths;
  - selectable trellis termination mode;
  - valid/ready branch-metric input;
  - per-step indexed output;
  - subtract-max normalisation with saturation.
- Sits between the branch-metric (gamma) unit and the LLR/extrinsic stage. The gamma unit feeds branch metrics in reverse time order.

---
 rtl/map_beta_recursion_pkg.sv | 40 ++++
 rtl/map_beta_recursion_beta_acs.sv | 25 ++
 rtl/map_beta_recursion.sv | 159 +++++++++++++++
 tb/tb_map_beta_recursion.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/map_beta_recursion_pkg.sv
// Shared trellis definition and helpers for the max-log-MAP beta recursion.
// Holds state count, FSM encoding, RSC (13,15) trellis functions, init and saturation helpers.
package map_pkg;

    localparam int NUM_STATES = 8;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_RUN  = 2'd2
    } state_t;

    // State s = {d1,d2,d3}; feedback bit a enters at d1.
    function automatic logic [2:0] next_state(input logic [2:0] s, input logic u);
        logic a;
        a = u ^ s[1] ^ s[0];
        return {a, s[2], s[1]};
    endfunction

    function automatic logic parity(input logic [2:0] s, input logic u);
        logic a;
        a = u ^ s[1] ^ s[0];
        return a ^ s[2] ^ s[0];
    endfunction

    // Metric given to the unreachable states of a terminated trellis.
    function automatic int neg_init(input int mw);
        return -(1 << (mw - 2));
    endfunction

    // Clamp a normalised metric into [-2^(mw-1), 0].
    function automatic int sat(input int x, input int mw);
        int lo;
        lo = -(1 << (mw - 1));
        if (x < lo) return lo;
        if (x > 0) return 0;
        return x;
    endfunction

endpackage

// File: rtl/map_beta_recursion_beta_acs.sv
// Add-compare-select for one trellis state of the backward recursion.
// Ports: beta_u0/1 successor metrics, g_u0/1 branch metrics, b = max of the two sums (MW+1 bits).
module beta_acs #(
    parameter int MW = 12,
    parameter int BW = 12
) (
    input  logic signed [MW-1:0] beta_u0,
    input  logic signed [MW-1:0] beta_u1,
    input  logic signed [BW-1:0] g_u0,
    input  logic signed [BW-1:0] g_u1,
    output logic signed [MW:0]   b
);

    logic signed [MW:0] c0;
    logic signed [MW:0] c1;

    // One extra bit so the sum of two full-range operands cannot wrap.
    assign c0 = $signed({beta_u0[MW-1], beta_u0})
              + $signed({{(MW+1-BW){g_u0[BW-1]}}, g_u0});
    assign c1 = $signed({beta_u1[MW-1], beta_u1})
              + $signed({{(MW+1-BW){g_u1[BW-1]}}, g_u1});

    assign b = (c1 > c0) ? c1 : c0;

endmodule

// File: rtl/map_beta_recursion.sv
// Max-log-MAP backward (beta) recursion for the 8-state turbo constituent code.
// Ports: start/term_mode/en control, gamma valid/ready + g00..g11, beta_out/valid/idx, busy, done.
module map_beta_recursion
    import map_pkg::*;
#(
    parameter int MW = 12,
    parameter int BW = 12,
    parameter int K  = 40,
    parameter int KW = 6
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 en,
    input  logic                 term_mode,
    input  logic                 gamma_valid,
    output logic                 gamma_ready,
    input  logic signed [BW-1:0] g00,
    input  logic signed [BW-1:0] g01,
    input  logic signed [BW-1:0] g10,
    input  logic signed [BW-1:0] g11,
    output logic [8*MW-1:0]      beta_out,
    output logic                 beta_valid,
    output logic [KW-1:0]        beta_idx,
    output logic                 busy,
    output logic                 done
);

    localparam logic signed [MW-1:0] NEG  = MW'(neg_init(MW));
    localparam logic [KW-1:0]        LAST = KW'(K - 1);

    state_t                state;
    state_t                state_nx;
    logic                  term_q;
    logic                  accept;
    logic [KW-1:0]         cnt;
    logic signed [MW-1:0]  beta_q [NUM_STATES];
    logic signed [BW-1:0]  g_arr  [4];
    logic signed [MW:0]    b      [NUM_STATES];
    logic signed [MW:0]    t1     [4];
    logic signed [MW:0]    t2     [2];
    logic signed [MW:0]    m;
    logic signed [MW+1:0]  diff   [NUM_STATES];
    logic signed [MW-1:0]  norm   [NUM_STATES];

    function automatic logic signed [MW:0] smax(
        input logic signed [MW:0] x,
        input logic signed [MW:0] y
    );
        return (y > x) ? y : x;
    endfunction

    // Branch metrics indexed by {u,p}.
    assign g_arr[0] = g00;
    assign g_arr[1] = g01;
    assign g_arr[2] = g10;
    assign g_arr[3] = g11;

    assign accept = (state == S_RUN) && en && gamma_valid;

    for (genvar s = 0; s < NUM_STATES; s++) begin : g_acs
        localparam logic [2:0] N0 = next_state(3'(s), 1'b0);
        localparam logic [2:0] N1 = next_state(3'(s), 1'b1);
        localparam logic       P0 = parity(3'(s), 1'b0);
        localparam logic       P1 = parity(3'(s), 1'b1);

        beta_acs #(
            .MW(MW),
            .BW(BW)
        ) u_acs (
            .beta_u0(beta_q[N0]),
            .beta_u1(beta_q[N1]),
            .g_u0   (g_arr[{1'b0, P0}]),
            .g_u1   (g_arr[{1'b1, P1}]),
            .b      (b[s])
        );
    end

    // Balanced max tree over the eight ACS results.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            t1[i] = smax(b[2*i], b[2*i+1]);
        end
        t2[0] = smax(t1[0], t1[1]);
        t2[1] = smax(t1[2], t1[3]);
        m     = smax(t2[0], t2[1]);
    end

    // Subtract-max keeps the best state at 0; weak states clamp at the floor.
    always_comb begin
        for (int s = 0; s < NUM_STATES; s++) begin
            diff[s] = $signed({b[s][MW], b[s]}) - $signed({m[MW], m});
            norm[s] = MW'(sat(int'(diff[s]), MW));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        if (en) begin
            unique case (state)
                S_IDLE:  if (start) state_nx = S_LOAD;
                S_LOAD:  state_nx = S_RUN;
                S_RUN:   if (gamma_valid && cnt == '0) state_nx = S_IDLE;
                default: state_nx = S_IDLE;
            endcase
        end
    end

    always_comb begin
        gamma_ready = (state == S_RUN) && en;
        busy        = (state != S_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            term_q     <= 1'b0;
            cnt        <= '0;
            beta_out   <= '0;
            beta_valid <= 1'b0;
            beta_idx   <= '0;
            done       <= 1'b0;
            for (int s = 0; s < NUM_STATES; s++) beta_q[s] <= '0;
        end else if (en) begin
            unique case (state)
                S_LOAD: begin
                    beta_valid <= 1'b0;
                    done       <= 1'b0;
                    cnt        <= LAST;
                    for (int s = 0; s < NUM_STATES; s++) begin
                        beta_q[s] <= (term_q && s != 0) ? NEG : '0;
                    end
                end
                S_RUN: begin
                    beta_valid <= gamma_valid;
                    done       <= gamma_valid && (cnt == '0);
                    if (accept) begin
                        beta_idx <= cnt;
                        cnt      <= cnt - KW'(1);
                        for (int s = 0; s < NUM_STATES; s++) begin
                            beta_q[s]             <= norm[s];
                            beta_out[s*MW +: MW]  <= norm[s];
                        end
                    end
                end
                default: begin
                    beta_valid <= 1'b0;
                    done       <= 1'b0;
                    if (start) term_q <= term_mode;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_map_beta_recursion.sv
// Self-checking bench for map_beta_recursion (MW=BW=12, K=8).
// Reference model recomputes each beta step from the trellis equations with integers.
module tb_map_beta_recursion;

    localparam int MW = 12;
    localparam int BW = 12;
    localparam int K  = 8;
    localparam int KW = 3;
    localparam int VW = 8 * MW;

    logic                 clk;
    logic                 rst;
    logic                 start;
    logic                 en;
    logic                 term_mode;
    logic                 gamma_valid;
    logic                 gamma_ready;
    logic signed [BW-1:0] g00;
    logic signed [BW-1:0] g01;
    logic signed [BW-1:0] g10;
    logic signed [BW-1:0] g11;
    logic [8*MW-1:0]      beta_out;
    logic                 beta_valid;
    logic [KW-1:0]        beta_idx;
    logic                 busy;
    logic                 done;

    map_beta_recursion #(
        .MW(MW), .BW(BW), .K(K), .KW(KW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .en         (en),
        .term_mode  (term_mode),
        .gamma_valid(gamma_valid),
        .gamma_ready(gamma_ready),
        .g00        (g00),
        .g01        (g01),
        .g10        (g10),
        .g11        (g11),
        .beta_out   (beta_out),
        .beta_valid (beta_valid),
        .beta_idx   (beta_idx),
        .busy       (busy),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors = 0;
    int errors  = 0;
    int mb[8];
    int eo[8];
    int e_idx;
    bit e_valid;
    bit e_done;
    bit running;
    int cnt;
    int dut_outs;

    task automatic chk(input string tag, input logic [VW-1:0] obs, input logic [VW-1:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [VW-1:0] exp_vec();
        logic [VW-1:0] v;
        v = '0;
        for (int s = 0; s < 8; s++) v[s*MW +: MW] = MW'(eo[s]);
        return v;
    endfunction

    function automatic int slot(input int s);
        return int'($signed(beta_out[s*MW +: MW]));
    endfunction

    task automatic check_all(input string tag);
        chk({tag, ".beta_out"}, beta_out, exp_vec());
        chk({tag, ".valid"}, VW'(beta_valid), VW'(e_valid));
        chk({tag, ".idx"}, VW'(beta_idx), VW'(e_idx));
        chk({tag, ".done"}, VW'(done), VW'(e_done));
        chk({tag, ".busy"}, VW'(busy), VW'(running));
    endtask

    // One backward step from the trellis rules, plain integer arithmetic.
    task automatic model_step(input int g0, input int g1, input int g2, input int g3);
        int gg[4];
        int b[8];
        int m;
        gg = '{g0, g1, g2, g3};
        for (int s = 0; s < 8; s++) begin
            int d1, d2, d3, best;
            d1 = (s >> 2) & 1;
            d2 = (s >> 1) & 1;
            d3 = s & 1;
            best = -(1 << 30);
            for (int u = 0; u < 2; u++) begin
                int a, p, ns, c;
                a  = u ^ d2 ^ d3;
                p  = a ^ d1 ^ d3;
                ns = (a << 2) | (d1 << 1) | d2;
                c  = mb[ns] + gg[2*u + p];
                if (c > best) best = c;
            end
            b[s] = best;
        end
        m = b[0];
        for (int s = 1; s < 8; s++) if (b[s] > m) m = b[s];
        for (int s = 0; s < 8; s++) begin
            int v;
            v = b[s] - m;
            if (v < -(1 << (MW - 1))) v = -(1 << (MW - 1));
            mb[s] = v;
            eo[s] = v;
        end
        e_valid = 1'b1;
        e_idx   = cnt;
        e_done  = (cnt == 0);
        if (cnt == 0) running = 1'b0;
        else          cnt--;
    endtask

    task automatic cycle(input int a0, input int a1, input int a2, input int a3,
                         input bit v, input bit e);
        g00 = BW'(a0);
        g01 = BW'(a1);
        g10 = BW'(a2);
        g11 = BW'(a3);
        gamma_valid = v;
        en = e;
        #1;
        chk("gamma_ready", VW'(gamma_ready), VW'(running && e));
        @(posedge clk);
        #1;
        if (e) begin
            if (running && v) model_step(a0, a1, a2, a3);
            else begin
                e_valid = 1'b0;
                e_done  = 1'b0;
            end
            if (beta_valid) dut_outs++;
        end
        check_all("step");
    endtask

    task automatic do_start(input bit term);
        start = 1'b1;
        term_mode = term;
        en = 1'b1;
        gamma_valid = 1'b0;
        @(posedge clk);
        #1;
        start = 1'b0;
        term_mode = ~term;
        e_valid = 1'b0;
        e_done  = 1'b0;
        chk("load.busy", VW'(busy), VW'(1'b1));
        chk("load.valid", VW'(beta_valid), VW'(1'b0));
        chk("load.ready", VW'(gamma_ready), VW'(1'b0));
        @(posedge clk);
        #1;
        running = 1'b1;
        cnt = K - 1;
        for (int s = 0; s < 8; s++) mb[s] = (term && s != 0) ? -(1 << (MW - 2)) : 0;
        check_all("run_entry");
        dut_outs = 0;
    endtask

    function automatic int rg();
        int r;
        r = int'($urandom_range(0, 9));
        if (r == 0) return 2047;
        if (r == 1) return -2048;
        return int'($urandom_range(0, 4095)) - 2048;
    endfunction

    task automatic run_rest(input int mode);
        int budget;
        budget = 400;
        while (running && budget > 0) begin
            unique case (mode)
                0: cycle(0, 0, 0, 0, 1'b1, 1'b1);
                1: cycle(5, 0, 0, 0, 1'b1, 1'b1);
                2: cycle(2047, -2048, -2048, -2048, 1'b1, 1'b1);
                default: begin
                    start = 1'($urandom_range(0, 1));
                    cycle(rg(), rg(), rg(), rg(),
                          $urandom_range(0, 3) != 0, $urandom_range(0, 5) != 0);
                end
            endcase
            budget--;
        end
        start = 1'b0;
        if (running) begin
            vectors++;
            errors++;
            $error("FAIL timeout: block still running after cycle budget");
            running = 1'b0;
        end
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        en = 1'b0;
        term_mode = 1'b0;
        gamma_valid = 1'b0;
        g00 = '0;
        g01 = '0;
        g10 = '0;
        g11 = '0;
        running = 1'b0;
        e_valid = 1'b0;
        e_done = 1'b0;
        e_idx = 0;
        cnt = 0;
        dut_outs = 0;
        for (int s = 0; s < 8; s++) begin
            mb[s] = 0;
            eo[s] = 0;
        end

        #12;
        check_all("reset");
        chk("reset.ready", VW'(gamma_ready), VW'(1'b0));
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Uniform init, zero metrics: K outputs, all zero, idx K-1..0.
        do_start(1'b0);
        run_rest(0);
        chk("zero.count", VW'(dut_outs), VW'(K));
        cycle(0, 0, 0, 0, 1'b1, 1'b1);

        // Terminated trellis; term_mode flips after start and must be ignored.
        do_start(1'b1);
        cycle(0, 0, 0, 0, 1'b1, 1'b1);
        chk("term.s0", VW'(slot(0)), VW'(0));
        chk("term.s1", VW'(slot(1)), VW'(0));
        chk("term.s2", VW'(slot(2)), VW'(-1024));
        chk("term.s7", VW'(slot(7)), VW'(-1024));
        run_rest(0);
        cycle(0, 0, 0, 0, 1'b0, 1'b1);

        // Single nonzero metric.
        do_start(1'b0);
        cycle(5, 0, 0, 0, 1'b1, 1'b1);
        chk("g5.s0", VW'(slot(0)), VW'(0));
        chk("g5.s2", VW'(slot(2)), VW'(-5));
        chk("g5.s5", VW'(slot(5)), VW'(-5));
        chk("g5.s6", VW'(slot(6)), VW'(0));
        run_rest(1);

        // Extreme metrics drive the weak states into saturation.
        do_start(1'b0);
        cycle(2047, -2048, -2048, -2048, 1'b1, 1'b1);
        chk("sat.s3", VW'(slot(3)), VW'(-2048));
        chk("sat.s4", VW'(slot(4)), VW'(-2048));
        chk("sat.s7", VW'(slot(7)), VW'(0));
        run_rest(2);

        // Stall with en=0 while gamma_valid toggles.
        do_start(1'($urandom_range(0, 1)));
        for (int i = 0; i < 3; i++) cycle(rg(), rg(), rg(), rg(), 1'b1, 1'b1);
        cycle(rg(), rg(), rg(), rg(), 1'b1, 1'b0);
        cycle(rg(), rg(), rg(), rg(), 1'b0, 1'b0);
        cycle(rg(), rg(), rg(), rg(), 1'b1, 1'b0);
        run_rest(0);
        chk("stall.count", VW'(dut_outs), VW'(K));

        // Asynchronous reset mid-block, then a full fresh block.
        do_start(1'b0);
        cycle(rg(), rg(), rg(), rg(), 1'b1, 1'b1);
        cycle(rg(), rg(), rg(), rg(), 1'b1, 1'b1);
        #3;
        rst = 1'b1;
        #1;
        running = 1'b0;
        e_valid = 1'b0;
        e_done = 1'b0;
        e_idx = 0;
        for (int s = 0; s < 8; s++) eo[s] = 0;
        check_all("midrst");
        chk("midrst.ready", VW'(gamma_ready), VW'(1'b0));
        @(posedge clk);
        #1;
        rst = 1'b0;
        do_start(1'($urandom_range(0, 1)));
        run_rest(3);
        chk("postrst.count", VW'(dut_outs), VW'(K));

        // Random blocks with random stalls and stray start pulses.
        for (int n = 0; n < 6; n++) begin
            do_start(1'($urandom_range(0, 1)));
            run_rest(3);
            chk("rand.count", VW'(dut_outs), VW'(K));
            cycle(0, 0, 0, 0, 1'b1, 1'b1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
